// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I/RV32E core with one shared req/ack memory port for fetch and load/store.
// Latency: 3 cycles (FETCH/EXEC/WB) for ALU/branch/jump, 4 for load/store, +1 per memory wait cycle.
// Backpressure: mem_req and its address/data/strobe are held until mem_ack; the core stalls meanwhile.
module rv32_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wstrb,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     retire,
  output logic                     halted,
  output logic                     trap,
  output logic [31:0]              debug_pc,
  output logic [NUM_REGS-1:0][31:0] debug_reg
);

  if (NUM_REGS != 32 && NUM_REGS != 16) begin : g_bad_num_regs
    $error("NUM_REGS must be 32 (RV32I) or 16 (RV32E)");
  end

  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t state, state_nxt;

  logic [31:0] pc, ir, next_pc_q, wb_val_q, ea_q, wdata_q;
  logic [3:0]  strb_q;
  logic        st_q, rd_we_q, trap_q;
  logic [31:0] regs [NUM_REGS];

  // instruction fields and immediates
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u  = {ir[31:12], 12'h000};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign rs1_val = (int'(rs1) < NUM_REGS) ? regs[rs1[AW-1:0]] : 32'h0;
  assign rs2_val = (int'(rs2) < NUM_REGS) ? regs[rs2[AW-1:0]] : 32'h0;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    alu = alt ? a - b : a + b;
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'b0, $signed(a) < $signed(b)};
      3'd3:    alu = {31'b0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  logic        ill, use_rd, use_rs1, use_rs2, is_ld, is_st, is_brk, jumps, br_taken;
  logic        bad_idx, mis_ls, exec_trap;
  logic [31:0] next_pc, wb_val, ea, st_data, ld_sh, ld_val;
  logic [3:0]  st_strb;

  // branch condition on the two source operands
  always_comb begin
    case (f3)
      3'd0:    br_taken = rs1_val == rs2_val;
      3'd1:    br_taken = rs1_val != rs2_val;
      3'd4:    br_taken = $signed(rs1_val) < $signed(rs2_val);
      3'd5:    br_taken = $signed(rs1_val) >= $signed(rs2_val);
      3'd6:    br_taken = rs1_val < rs2_val;
      3'd7:    br_taken = rs1_val >= rs2_val;
      default: br_taken = 1'b0;
    endcase
  end

  // decode: legality, operand usage, result, next pc and effective address
  always_comb begin
    ill = 1'b0; use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    is_ld = 1'b0; is_st = 1'b0; is_brk = 1'b0; jumps = 1'b0;
    wb_val = 32'h0; next_pc = pc + 32'd4; ea = rs1_val + imm_i;
    case (opcode)
      7'b0110111: begin use_rd = 1'b1; wb_val = imm_u; end
      7'b0010111: begin use_rd = 1'b1; wb_val = pc + imm_u; end
      7'b1101111: begin use_rd = 1'b1; wb_val = pc + 32'd4; next_pc = pc + imm_j; jumps = 1'b1; end
      7'b1100111: begin
        use_rd = 1'b1; use_rs1 = 1'b1; wb_val = pc + 32'd4; jumps = 1'b1;
        next_pc = (rs1_val + imm_i) & ~32'h1; ill = (f3 != 3'd0);
      end
      7'b1100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; ill = (f3 == 3'd2) || (f3 == 3'd3);
        if (br_taken) begin next_pc = pc + imm_b; jumps = 1'b1; end
      end
      7'b0000011: begin
        use_rd = 1'b1; use_rs1 = 1'b1; is_ld = 1'b1;
        ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      7'b0100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; is_st = 1'b1; ea = rs1_val + imm_s; ill = (f3 > 3'd2);
      end
      7'b0010011: begin
        use_rd = 1'b1; use_rs1 = 1'b1;
        wb_val = alu(rs1_val, imm_i, f3, (f3 == 3'd5) && ir[30]);
        if (f3 == 3'd1) ill = (f7 != 7'h00);
        if (f3 == 3'd5) ill = (f7 != 7'h00) && (f7 != 7'h20);
      end
      7'b0110011: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        wb_val = alu(rs1_val, rs2_val, f3, ir[30]);
        ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      7'b0001111: ;  // FENCE: single in-order port, nothing to order
      7'b1110011: begin
        if (ir == 32'h0010_0073) is_brk = 1'b1;
        else if (ir != 32'h0000_0073) ill = 1'b1;  // ECALL runs as a NOP
      end
      default: ill = 1'b1;
    endcase
  end

  assign bad_idx = (use_rd && int'(rd) >= NUM_REGS) || (use_rs1 && int'(rs1) >= NUM_REGS) ||
                   (use_rs2 && int'(rs2) >= NUM_REGS);
  assign mis_ls  = (is_ld || is_st) &&
                   (((f3[1:0] == 2'b01) && ea[0]) || ((f3[1:0] == 2'b10) && (ea[1:0] != 2'b00)));
  assign exec_trap = ill || bad_idx || mis_ls || (jumps && next_pc[1]);

  // store lane placement: replicate the datum, strobe only the addressed lanes
  always_comb begin
    case (f3[1:0])
      2'b00:   begin st_data = {4{rs2_val[7:0]}};  st_strb = 4'b0001 << ea[1:0]; end
      2'b01:   begin st_data = {2{rs2_val[15:0]}}; st_strb = 4'b0011 << ea[1:0]; end
      default: begin st_data = rs2_val;            st_strb = 4'b1111; end
    endcase
  end

  // load extraction from the returned word, sign/zero extended by funct3
  assign ld_sh = mem_rdata >> {ea_q[1:0], 3'b000};
  always_comb begin
    case (f3)
      3'd0:    ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'd1:    ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'd4:    ld_val = {24'h0, ld_sh[7:0]};
      3'd5:    ld_val = {16'h0, ld_sh[15:0]};
      default: ld_val = ld_sh;
    endcase
  end

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // next-state: memory states wait for ack, EXEC picks halt/mem/writeback
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (mem_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        if (exec_trap || is_brk)  state_nxt = S_HALT;
        else if (is_ld || is_st)  state_nxt = S_MEM;
        else                      state_nxt = S_WB;
      end
      S_MEM:   if (mem_ack) state_nxt = S_WB;
      S_WB:    state_nxt = S_FETCH;
      default: state_nxt = S_HALT;
    endcase
  end

  // outputs: request gated by reset so a pending access is dropped immediately
  always_comb begin
    mem_req   = !reset && ((state == S_FETCH) || (state == S_MEM));
    mem_we    = (state == S_MEM) && st_q;
    mem_addr  = (state == S_MEM) ? ea_q : pc;
    mem_wdata = wdata_q;
    mem_wstrb = ((state == S_MEM) && st_q) ? strb_q : 4'b0000;
    retire    = (state == S_WB);
    halted    = (state == S_HALT);
  end

  // datapath registers: instruction latch, EXEC results, load capture, writeback
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC; ir <= 32'h0; next_pc_q <= 32'h0; wb_val_q <= 32'h0;
      ea_q <= 32'h0; wdata_q <= 32'h0; strb_q <= 4'h0; st_q <= 1'b0;
      rd_we_q <= 1'b0; trap_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
    end else begin
      case (state)
        S_FETCH: if (mem_ack) ir <= mem_rdata;
        S_EXEC: begin
          next_pc_q <= next_pc;
          wb_val_q  <= wb_val;
          rd_we_q   <= use_rd && (rd != 5'd0);
          ea_q      <= ea;
          wdata_q   <= st_data;
          strb_q    <= st_strb;
          st_q      <= is_st;
          if (exec_trap) trap_q <= 1'b1;
        end
        S_MEM: if (mem_ack && !st_q) wb_val_q <= ld_val;
        S_WB: begin
          if (rd_we_q) regs[rd[AW-1:0]] <= wb_val_q;
          pc <= next_pc_q;
        end
        default: ;
      endcase
    end
  end

  // debug snapshot; entry 0 is hard zero
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) debug_reg[i] = regs[i];
    debug_reg[0] = 32'h0;
  end

  assign trap     = trap_q;
  assign debug_pc = pc;

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Scoreboard bench: expected retire results and store beats are queued as the program is loaded,
// then popped and compared as the core retires instructions and issues stores.
// A second core instance built as RV32E checks the out-of-range register trap.
module tb_rv32_multicycle_core;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // main core, RV32I, reset vector 0x100
  logic        mem_req, mem_we, mem_ack, retire, halted, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, debug_pc;
  logic [3:0]  mem_wstrb;
  logic [31:0][31:0] debug_reg;

  rv32_multicycle_core #(.RESET_PC(32'h100), .NUM_REGS(32)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .retire(retire), .halted(halted), .trap(trap), .debug_pc(debug_pc), .debug_reg(debug_reg));

  // RV32E core, reset vector 0
  logic        req2, we2, ack2, retire2, halted2, trap2;
  logic [31:0] addr2, wdata2, rdata2, pc2;
  logic [3:0]  wstrb2;
  logic [15:0][31:0] dbg2;

  rv32_multicycle_core #(.RESET_PC(32'h0), .NUM_REGS(16)) dut_e (
    .clock(clock), .reset(reset), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
    .mem_wdata(wdata2), .mem_wstrb(wstrb2), .mem_ack(ack2), .mem_rdata(rdata2),
    .retire(retire2), .halted(halted2), .trap(trap2), .debug_pc(pc2), .debug_reg(dbg2));

  // memory models: main one has wait states on fetch@0x11C and reads of 0x200
  logic [31:0] mem  [0:1023];
  logic [31:0] mem2 [0:15];
  logic        stall = 1'b0;
  int          wcnt, dly;

  assign dly       = (!mem_we && (mem_addr == 32'h11C || mem_addr == 32'h200)) ? 3 : 0;
  assign mem_ack   = mem_req && !stall && (wcnt >= dly);
  assign mem_rdata = mem[mem_addr[11:2]];
  assign ack2      = req2;
  assign rdata2    = mem2[addr2[5:2]];

  always @(posedge clock) begin
    if (reset || !mem_req || mem_ack) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
  end

  int cyc;
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct { int rd; logic [31:0] val; logic [31:0] pc; int cy; } ret_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } st_t;
  ret_t ret_q[$];
  st_t  st_q[$];

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  // place an instruction and queue its expected architectural effect
  task automatic put(input logic [31:0] a, input logic [31:0] ins, input int rd,
                     input logic [31:0] val, input logic [31:0] npc, input int cy);
    ret_t e;
    mem[a[11:2]] = ins;
    e = '{rd: rd, val: val, pc: npc, cy: cy};
    ret_q.push_back(e);
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      @(negedge clock);
    end
  endtask

  // bus/retire monitor: hold-until-ack, store beats, retire timing and results
  logic        pend = 1'b0, chk_now = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_strb;
  logic        h_we;
  int          last_ret = -1;
  ret_t        cur;
  st_t         s;
  always @(negedge clock) begin
    if (reset) begin
      pend = 1'b0; chk_now = 1'b0; last_ret = -1;
    end else begin
      if (chk_now) begin
        check($sformatf("reg_x%0d", cur.rd), debug_reg[cur.rd], cur.val);
        check("next_pc", debug_pc, cur.pc);
        chk_now = 1'b0;
      end
      if (pend) begin
        check("req_held", 32'(mem_req), 32'd1);
        check("addr_held", mem_addr, h_addr);
        check("we_held", 32'(mem_we), 32'(h_we));
        check("wdata_held", mem_wdata, h_wdata);
        check("strb_held", 32'(mem_wstrb), 32'(h_strb));
      end
      if (mem_req && mem_ack) begin
        if (mem_we) begin
          if (st_q.size() == 0) check("st_unexp", 32'(mem_we), 32'd0);
          else begin
            s = st_q.pop_front();
            check("st_addr", mem_addr, s.addr);
            check("st_wdata", mem_wdata, s.data);
            check("st_wstrb", 32'(mem_wstrb), 32'(s.strb));
          end
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          check("rd_wstrb", 32'(mem_wstrb), 32'd0);
        end
      end
      pend = mem_req && !mem_ack;
      h_addr = mem_addr; h_wdata = mem_wdata; h_strb = mem_wstrb; h_we = mem_we;
      if (retire) begin
        if (ret_q.size() == 0) check("ret_unexp", 32'(retire), 32'd0);
        else begin
          cur = ret_q.pop_front();
          check($sformatf("cycles@%h", debug_pc), 32'(cyc - last_ret), 32'(cur.cy));
          chk_now = 1'b1;
        end
        last_ret = cyc;
      end
    end
  end

  initial begin
    st_t e;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) mem2[i] = 32'h0;
    #1 reset = 1'b1;

    // program A: ALU, loads of 0x8081_82F3, stores, branches, jumps, x0, EBREAK
    mem[32'h200 >> 2] = 32'h8081_82F3;
    put(32'h100, enc_i(5, 0, 0, 1, 7'h13),       1, 32'h5,         32'h104, 3);
    put(32'h104, enc_i(-7, 1, 0, 2, 7'h13),      2, 32'hFFFF_FFFE, 32'h108, 3);
    put(32'h108, enc_i(32'h200, 0, 0, 3, 7'h13), 3, 32'h200,       32'h10C, 3);
    put(32'h10C, enc_i(0, 3, 0, 4, 7'h03),       4, 32'hFFFF_FFF3, 32'h110, 7);
    put(32'h110, enc_i(1, 3, 4, 5, 7'h03),       5, 32'h82,        32'h114, 4);
    put(32'h114, enc_i(2, 3, 1, 6, 7'h03),       6, 32'hFFFF_8081, 32'h118, 4);
    put(32'h118, enc_i(2, 3, 5, 7, 7'h03),       7, 32'h8081,      32'h11C, 4);
    put(32'h11C, enc_i(0, 3, 2, 8, 7'h03),       8, 32'h8081_82F3, 32'h120, 10);
    put(32'h120, enc_i(32'hAB, 0, 0, 9, 7'h13),  9, 32'hAB,        32'h124, 3);
    put(32'h124, enc_s(3, 9, 3, 0),              9, 32'hAB,        32'h128, 4);
    e = '{addr: 32'h203, data: 32'hABAB_ABAB, strb: 4'b1000}; st_q.push_back(e);
    put(32'h128, enc_s(2, 9, 3, 1),              9, 32'hAB,        32'h12C, 4);
    e = '{addr: 32'h202, data: 32'h00AB_00AB, strb: 4'b1100}; st_q.push_back(e);
    put(32'h12C, enc_i(0, 3, 2, 10, 7'h03),     10, 32'h00AB_82F3, 32'h130, 7);
    put(32'h130, enc_b(8, 1, 1, 0),              1, 32'h5,         32'h138, 3);
    put(32'h138, enc_b(8, 2, 1, 0),              2, 32'hFFFF_FFFE, 32'h13C, 3);
    put(32'h13C, enc_j(8, 12),                  12, 32'h140,       32'h144, 3);
    put(32'h144, enc_i(32'h155, 0, 0, 13, 7'h13), 13, 32'h155,     32'h148, 3);
    put(32'h148, enc_i(0, 13, 0, 14, 7'h67),    14, 32'h14C,       32'h154, 3);
    put(32'h154, enc_i(1, 0, 0, 0, 7'h13),       0, 32'h0,         32'h158, 3);
    put(32'h158, enc_r(32'h20, 1, 2, 0, 15),    15, 32'hFFFF_FFF9, 32'h15C, 3);
    put(32'h15C, enc_r(0, 1, 2, 2, 16),         16, 32'h1,         32'h160, 3);
    put(32'h160, enc_r(0, 1, 2, 3, 17),         17, 32'h0,         32'h164, 3);
    put(32'h164, enc_i(32'h401, 2, 5, 18, 7'h13), 18, 32'hFFFF_FFFF, 32'h168, 3);
    put(32'h168, enc_i(3, 1, 1, 19, 7'h13),     19, 32'h28,        32'h16C, 3);
    mem[32'h16C >> 2] = 32'h0010_0073;

    // RV32E program: x5 = 7, then x20 referenced
    mem2[0] = enc_i(7, 0, 0, 5, 7'h13);
    mem2[1] = enc_i(1, 0, 0, 20, 7'h13);

    @(negedge clock);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_pc", debug_pc, 32'h100);
    check("rst_x1", debug_reg[1], 32'h0);

    @(negedge clock);
    reset = 1'b0;
    #1;
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, 32'h100);

    wait_halt(2000);
    @(negedge clock);
    check("a_halted", 32'(halted), 32'd1);
    check("a_trap", 32'(trap), 32'd0);
    check("a_ret_left", 32'(ret_q.size()), 32'd0);
    check("a_st_left", 32'(st_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("halt_req", 32'(mem_req), 32'd0);
      check("halt_pc", debug_pc, 32'h16C);
    end

    check("e_halted", 32'(halted2), 32'd1);
    check("e_trap", 32'(trap2), 32'd1);
    check("e_x5", dbg2[5], 32'h7);
    check("e_pc", pc2, 32'h4);

    // program B: reset abandons a stalled fetch, then a misaligned LW traps
    reset = 1'b1;
    put(32'h100, enc_i(32'h202, 0, 0, 3, 7'h13), 3, 32'h202, 32'h104, 3);
    mem[32'h104 >> 2] = enc_i(0, 3, 2, 4, 7'h03);
    stall = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("stall_req", 32'(mem_req), 32'd1);
    check("stall_addr", mem_addr, 32'h100);
    #2 reset = 1'b1;
    #1;
    check("rst_drop_req", 32'(mem_req), 32'd0);
    check("rst_drop_pc", debug_pc, 32'h100);
    @(negedge clock);
    stall = 1'b0;
    reset = 1'b0;
    #1;
    check("restart_addr", mem_addr, 32'h100);

    wait_halt(200);
    @(negedge clock);
    check("b_halted", 32'(halted), 32'd1);
    check("b_trap", 32'(trap), 32'd1);
    check("b_pc", debug_pc, 32'h104);
    check("b_req", 32'(mem_req), 32'd0);
    check("b_x4", debug_reg[4], 32'h0);
    check("b_ret_left", 32'(ret_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
